// File: rtl/layer0_input_pkg.sv
// Shared constants, threshold table and FSM state type for the layer-0 input packer.
package layer0_input_pkg;

  localparam int N_FEAT_DEF = 16;
  localparam int IN_W_DEF   = 16;
  localparam int Q_W        = 2;
  localparam int N_THR      = 3;

  typedef logic [IN_W_DEF-1:0] thresh_arr_t [N_FEAT_DEF][N_THR];

  // Ascending per feature; a narrower IN_W uses the top bits of each entry.
  localparam thresh_arr_t THRESH = '{default: '{16'h4000, 16'h8000, 16'hC000}};

  typedef enum logic {FILL, SKIP} state_e;

endpackage

// File: rtl/feat_quantizer.sv
// Combinational 2-bit quantiser: code = number of thresholds of the selected
// feature that the sample meets or exceeds.
module feat_quantizer import layer0_input_pkg::*; #(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int IN_W   = IN_W_DEF,
  parameter int IDX_W  = $clog2(N_FEAT)
) (
  input  logic [IDX_W-1:0] feat_idx_i,
  input  logic [IN_W-1:0]  s_data_i,
  output logic [Q_W-1:0]   code_o
);

  localparam int FW = $clog2(N_FEAT_DEF);
  localparam int SH = IN_W_DEF - IN_W;

  logic [FW-1:0]       feat;
  logic [IN_W_DEF-1:0] sample;

  assign feat   = FW'(feat_idx_i);
  assign sample = IN_W_DEF'(s_data_i);

  always_comb begin
    code_o = '0;
    for (int k = 0; k < N_THR; k++) begin
      if (sample >= (THRESH[feat][k] >> SH)) code_o = code_o + Q_W'(1);
    end
  end

endmodule

// File: rtl/layer0_input_packer.sv
// Quantises raw feature beats and packs them into a double-buffered vector for layer 0.
// Define LAYER0_INPUT_PACKER_STATS_EN to add saturating vec_cnt/err_cnt outputs.
module layer0_input_packer import layer0_input_pkg::*; #(
  parameter int N_FEAT = N_FEAT_DEF,
  parameter int IN_W   = IN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_W-1:0]       s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [N_FEAT*Q_W-1:0] m_data,
  output logic                  err
`ifdef LAYER0_INPUT_PACKER_STATS_EN
  ,
  output logic [15:0]           vec_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam int               IDX_W    = $clog2(N_FEAT);
  localparam int               VW       = N_FEAT * Q_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [VW-1:0]    asm_q, asm_d;
  logic [VW-1:0]    m_data_q;
  logic             m_valid_q;
  logic             err_q;

  logic [Q_W-1:0]   code;
  logic             accept, in_fill, at_last, vec_load, frame_err;

  feat_quantizer #(
    .N_FEAT (N_FEAT),
    .IN_W   (IN_W),
    .IDX_W  (IDX_W)
  ) u_quant (
    .feat_idx_i (idx_q),
    .s_data_i   (s_data),
    .code_o     (code)
  );

  assign in_fill   = (state_q == FILL);
  assign at_last   = (idx_q == IDX_LAST);
  // Only the closing beat needs the output register free; earlier beats overlap the hold.
  assign s_ready   = !(in_fill && at_last && m_valid_q && !m_ready);
  assign accept    = s_valid && s_ready;
  assign vec_load  = accept && in_fill && at_last && s_last;
  assign frame_err = accept && in_fill && (at_last ^ s_last);

  always_comb begin
    asm_d = asm_q;
    asm_d[int'(idx_q)*Q_W +: Q_W] = code;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      asm_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= frame_err;
      if (m_valid_q && m_ready) m_valid_q <= 1'b0;
      if (vec_load) begin
        m_data_q  <= asm_d;
        m_valid_q <= 1'b1;
      end
      if (accept) begin
        case (state_q)
          FILL: begin
            if (!at_last && !s_last) begin
              asm_q <= asm_d;
              idx_q <= idx_q + IDX_W'(1);
            end else begin
              idx_q <= '0;
              if (at_last && s_last) asm_q <= asm_d;
              if (at_last && !s_last) state_q <= SKIP;
            end
          end
          SKIP: begin
            if (s_last) begin
              state_q <= FILL;
              idx_q   <= '0;
            end
          end
          default: state_q <= FILL;
        endcase
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

`ifdef LAYER0_INPUT_PACKER_STATS_EN
  logic [15:0] vec_cnt_q, err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (vec_load && vec_cnt_q != 16'hFFFF) vec_cnt_q <= vec_cnt_q + 16'd1;
      if (frame_err && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign vec_cnt = vec_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_layer0_input_packer.sv
// Scoreboard bench for layer0_input_packer with a frame-level reference model.
module tb_layer0_input_packer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int DW = N * 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          err;
`ifdef LAYER0_INPUT_PACKER_STATS_EN
  logic [15:0]   vec_cnt, err_cnt;
`endif

  layer0_input_packer #(.N_FEAT(N), .IN_W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .err     (err)
`ifdef LAYER0_INPUT_PACKER_STATS_EN
    ,
    .vec_cnt (vec_cnt),
    .err_cnt (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: beats seen in the current frame and whether it already erred.
  logic [DW-1:0] exp_q[$];
  logic [1:0]    m_codes[$];
  int            m_cnt = 0;
  bit            m_flag = 0;
  int            err_due = -1;
  int            vec_total = 0;
  int            err_total = 0;
  bit            mr_force = 1;
  bit            mr_val = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] quant(input logic [7:0] d);
    int c = 0;
    if (d >= 64)  c++;
    if (d >= 128) c++;
    if (d >= 192) c++;
    return 2'(c);
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic l);
    logic [DW-1:0] v;
    m_codes.push_back(quant(d));
    if (!m_flag) begin
      if (l && m_cnt + 1 == N) begin
        v = '0;
        for (int i = 0; i < N; i++) v[2*i +: 2] = m_codes[i];
        exp_q.push_back(v);
        vec_total++;
      end else if (l != (m_cnt + 1 == N)) begin
        err_due = cyc;
        err_total++;
        if (!l) m_flag = 1;
      end
    end
    if (l) begin
      m_cnt = 0;
      m_flag = 0;
      m_codes.delete();
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_flag = 0;
    m_codes.delete();
    exp_q.delete();
    err_due = -1;
    vec_total = 0;
    err_total = 0;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int w = 0;
    bit done = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!done) begin
      @(negedge clk);
      if (m_flag || m_cnt != N - 1 || m_ready) chk("s_ready_open", s_ready, 1);
      if (s_ready) done = 1;
      @(posedge clk);
      #1;
      if (!done) begin
        w++;
        if (w > 200) begin
          checks++;
          errors++;
          $display("FAIL beat_timeout: s_ready got 0 for 200 cycles expected 1");
          s_valid = 1'b0;
          return;
        end
      end
    end
    model_accept(d, l);
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int len);
    logic [7:0] edges [8];
    logic [7:0] d;
    edges = '{8'd0, 8'd63, 8'd64, 8'd127, 8'd128, 8'd191, 8'd192, 8'd255};
    for (int b = 0; b < len; b++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      d = ($urandom_range(0, 1) == 1) ? edges[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      send_beat(d, b == len - 1);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_ready = mr_force ? mr_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: err timing, held-data stability and vector order against the scoreboard.
  initial begin
    logic          pv, pr;
    logic [DW-1:0] pd;
    pv = 0;
    pr = 0;
    pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        pr = 0;
        continue;
      end
      chk("err_pulse", err, cyc == err_due);
      if (pv && !pr && m_valid) chk("hold_stable", m_data, pd);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_vec: got %0h expected no vector", m_data);
        end else begin
          chk("vec_data", m_data, exp_q.pop_front());
        end
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
    end
  end

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_m_data", m_data, 0);
    @(posedge clk);
    #1;

    // Clean frame
    send_beat(8'd10, 0);
    send_beat(8'd64, 0);
    send_beat(8'd191, 0);
    send_beat(8'd255, 1);
    @(negedge clk);
    chk("clean_valid", m_valid, 1);
    chk("clean_data", m_data, 8'b11_10_01_00);
    @(posedge clk);
    #1;

    // Back-pressure: one vector held, second frame stalls on its final beat
    mr_val = 0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(8'd200, 0);
    send_beat(8'd150, 0);
    send_beat(8'd70, 0);
    send_beat(8'd5, 1);
    send_beat(8'd1, 0);
    send_beat(8'd128, 0);
    send_beat(8'd192, 0);
    s_valid = 1'b1;
    s_data  = 8'd100;
    s_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", s_ready, 0);
      chk("bp_held_valid", m_valid, 1);
    end
    mr_val = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", s_ready, 1);
    @(posedge clk);
    #1;
    model_accept(8'd100, 1);
    s_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", m_valid, 1);
    chk("bp_second_data", m_data, 8'b01_11_10_00);
    @(posedge clk);
    #1;

    // Short frame, then a good frame
    send_beat(8'd33, 0);
    send_beat(8'd99, 1);
    send_frame(N);

    // Long frame, then a good frame
    send_frame(6);
    send_frame(N);

    // Reset in the middle of a vector
    repeat (3) @(posedge clk);
    #1;
    send_beat(8'd250, 0);
    send_beat(8'd130, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_m_valid", m_valid, 0);
    chk("postrst_m_data", m_data, 0);
    @(posedge clk);
    #1;
    send_beat(8'd0, 0);
    send_beat(8'd255, 0);
    send_beat(8'd127, 0);
    send_beat(8'd192, 1);
    @(negedge clk);
    chk("postrst_data", m_data, 8'b11_01_11_00);
    @(posedge clk);
    #1;

    // Randomised frames with random back-pressure
    mr_force = 0;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) < 7) send_frame(N);
      else send_frame($urandom_range(1, 6));
    end

    mr_force = 1;
    mr_val = 1;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drain_m_valid", m_valid, 0);
`ifdef LAYER0_INPUT_PACKER_STATS_EN
    chk("vec_cnt", vec_cnt, vec_total);
    chk("err_cnt", err_cnt, err_total);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer0_input_packer.md
# layer0_input_packer

Streaming front end directly upstream of the first LogicNet layer. Accepts raw unsigned feature samples one per beat, quantises each to a 2-bit code against per-feature thresholds, and assembles a complete feature vector in a double-buffered register. The packed vector is presented to the layer-0 neuron LUT fan-out with a valid/ready handshake.

## Interface
- N_FEAT, 16, features per vector; must be at least 2
- IN_W, 16, raw feature width, unsigned
- Q_W, 2, quantised code width; fixed, 3 thresholds per feature
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- s_valid  input  1  raw sample valid
- s_ready  output  1  sample accepted when s_valid && s_ready
- s_data  input  IN_W  raw feature value
- s_last  input  1  marks final feature of a vector
- m_valid  output  1  packed vector valid
- m_ready  input  1  downstream accepts
- m_data  output  N_FEAT*Q_W  packed codes, feature i in bits [2i+1:2i]
- err  output  1  one-cycle framing-error pulse

## Operation
- Quantisation: code = count of thresholds T[i][k], k=0..2, with s_data >= T[i][k]. The result ranges 0..3. Thresholds are ascending per feature and come from the package.
- The code for the accepted beat is written into the assembly buffer at index idx. The write is combinational from s_data, with no extra register stage.
- idx counts 0..N_FEAT-1 and is clog2(N_FEAT) bits wide.
- The FSM has two states: FILL and SKIP.
- FILL, beat accepted with idx < N_FEAT-1 and s_last=0: store the code, idx++.
- FILL, beat accepted with idx < N_FEAT-1 and s_last=1: short frame. Pulse err, discard the partial vector, idx=0, stay in FILL.
- FILL, beat accepted with idx == N_FEAT-1 and s_last=1: store the code, move the assembly buffer to the output register, set m_valid, idx=0.
- FILL, beat accepted with idx == N_FEAT-1 and s_last=0: long frame. Pulse err, discard, go to SKIP.
- SKIP: accept and drop beats, s_ready=1. On an accepted beat with s_last=1, go to FILL with idx=0. No further err pulses.
- Output register: m_valid clears on m_valid && m_ready unless a new vector loads in the same cycle, in which case m_valid stays 1 and m_data updates.
- Back-pressure: s_ready = 0 only when state==FILL && idx==N_FEAT-1 && m_valid && !m_ready. Otherwise s_ready=1.
- Assembly of the next vector proceeds while the previous vector is held in the output register.
- m_data is stable while m_valid && !m_ready.

## Timing
- Reset values: state=FILL, idx=0, m_valid=0, m_data=0, err=0, assembly buffer=0. s_ready is 1 out of reset.
- Reset mid-vector discards all partial and held data. The first beat after reset deassertion is feature 0.
- Latency: a final beat accepted at edge t gives m_valid=1 after edge t. This is 1 cycle.
- err is registered. It is high for exactly the cycle after the offending beat is accepted.
- Throughput: one beat per cycle sustained. A new vector every N_FEAT cycles when m_ready=1.
- s_ready has a combinational path from m_ready.

## Configuration
- LAYER0_INPUT_PACKER_STATS_EN defined adds two output ports:
  - vec_cnt: 16 bits, vectors emitted.
  - err_cnt: 16 bits, framing errors.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package layer0_input_pkg holds:
  - constants N_FEAT_DEF and Q_W;
  - the threshold array type;
  - the constant THRESH[N_FEAT][3] of IN_W-bit values;
  - the FSM state enum {FILL, SKIP}.
- One sub-module, feat_quantizer: purely combinational, maps (s_data, feature index) to a 2-bit code via a threshold lookup.
- The FSM, idx counter, double buffer and optional stats stay in the top module.

## Test plan
All scenarios use N_FEAT=4, IN_W=8 and thresholds {64,128,192} for all features.
- Clean frame: beats 10, 64, 191, 255 with s_last on the 4th beat, m_ready=1. Expect m_valid one cycle later with m_data=8'b11_10_01_00, and err=0.
- Back-pressure: hold m_ready=0 after the first vector and send a second full frame. Expect s_ready=0 on the 4th beat, first-vector m_data held stable. Raise m_ready: second vector appears the next cycle, with no beat lost.
- Short frame: s_last on the 2nd beat. Expect an err pulse of 1 cycle, no m_valid; the following 4-beat frame is emitted correctly.
- Long frame: 6 beats with s_last on the 6th. Expect err after the 4th beat, beats 5–6 dropped, no m_valid; the next frame is emitted correctly.
- Reset mid-vector: assert rst after 2 beats. Expect m_valid=0, idx=0; the next 4-beat frame is emitted intact.
- With STATS_EN, 3 good frames and 1 short frame: expect vec_cnt=3 and err_cnt=1.
